// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the master drives the request, the slave returns the result.
// Handshake: slave holds ready high while idle; a request is taken on any rising edge with start && ready, and done pulses one cycle when sum/cout/ovf update.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             done;

  modport master (
    output start, sub, a, b, cin,
    input  ready, sum, cout, ovf, done
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, sum, cout, ovf, done
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB slice first, WIDTH/DIGIT cycles per operation.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus,
  output logic          dbg_run_o
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic [DIGIT:0]   slice_d;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;
  logic             last_d;

  // Operands shift right each cycle, so the active slice is always the low DIGIT bits.
  always_comb begin
    slice_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    acc_d   = (acc_q >> DIGIT) | (WIDTH'(slice_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Carry into the MSB is recovered from the MSB's sum bit and its two inputs.
    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_d[DIGIT-1] ^ slice_d[DIGIT];
    last_d  = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= slice_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            sum_q   <= acc_d;
            cout_q  <= slice_d[DIGIT];
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.done  = done_q;
  assign dbg_run_o = (state_q == S_RUN);
endmodule
